// File: rtl/parking_gate_controller_pkg.sv
// Shared types and defaults for the parking gate controller.
// Gate FSM states and direction encodings.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OPEN_IN,
    OPEN_OUT,
    CLOSE
  } gate_state_t;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  localparam int DEF_CAPACITY     = 8;
  localparam int DEF_GATE_TIMEOUT = 50;

endpackage

// File: rtl/parking_gate_controller_if.sv
// Sensor/status bundle between debouncers, gate controller and display.
// master drives sensors and observes status; slave is the controller.
interface parking_gate_if #(
  parameter int CNT_W = 4
);

  logic             entry_req;
  logic             exit_req;
  logic             entry_pass;
  logic             exit_pass;
  logic             gate_open;
  logic             gate_dir;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] free_spaces;
  logic             full;
  logic             empty;
  logic             reject;
  logic             timeout;

  modport master (
    output entry_req,
    output exit_req,
    output entry_pass,
    output exit_pass,
    input  gate_open,
    input  gate_dir,
    input  occupancy,
    input  free_spaces,
    input  full,
    input  empty,
    input  reject,
    input  timeout
  );

  modport slave (
    input  entry_req,
    input  exit_req,
    input  entry_pass,
    input  exit_pass,
    output gate_open,
    output gate_dir,
    output occupancy,
    output free_spaces,
    output full,
    output empty,
    output reject,
    output timeout
  );

endinterface

// File: rtl/parking_gate_controller_edge_detect.sv
// Single-bit rising-edge detector for debounced sensor levels.
// Previous value resets high so a level held through reset is not an edge.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_prev <= 1'b1;
    else        r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/parking_gate_controller.sv
// Shared-barrier parking gate controller with occupancy tracking.
// Exit requests take priority; one-deep pending flags hold requests while busy.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int CNT_W        = 4,
  parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT,
  parameter int TMR_W        = 6
) (
  input logic           clk,
  input logic           reset,
  parking_gate_if.slave bus
);

  localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TMO_V = TMR_W'(GATE_TIMEOUT - 1);

  gate_state_t      r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_pend_in;
  logic             r_pend_out;
  logic             r_gate_open;
  logic             r_gate_dir;
  logic [CNT_W-1:0] r_occ;
  logic [CNT_W-1:0] r_free;
  logic             r_full;
  logic             r_empty;
  logic             r_reject;
  logic             r_timeout;

  logic             w_e_ereq;
  logic             w_e_xreq;
  logic             w_e_epass;
  logic             w_e_xpass;
  logic             w_src_in;
  logic             w_src_out;
  logic             w_pass;
  logic             w_inc;
  logic             w_dec;
  logic [CNT_W-1:0] w_occ_nxt;

  edge_detect u_ed_ereq (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.entry_req),
    .o_rise(w_e_ereq)
  );

  edge_detect u_ed_xreq (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.exit_req),
    .o_rise(w_e_xreq)
  );

  edge_detect u_ed_epass (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.entry_pass),
    .o_rise(w_e_epass)
  );

  edge_detect u_ed_xpass (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.exit_pass),
    .o_rise(w_e_xpass)
  );

  assign w_src_in  = w_e_ereq | r_pend_in;
  assign w_src_out = w_e_xreq | r_pend_out;

  assign w_pass = ((r_state == OPEN_IN) && w_e_epass) ||
                  ((r_state == OPEN_OUT) && w_e_xpass);

  assign w_inc = (r_state == OPEN_IN) && w_e_epass &&
                 (r_occ != CAP_V);
  assign w_dec = (r_state == OPEN_OUT) && w_e_xpass &&
                 (r_occ != '0);

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_inc)      w_occ_nxt = r_occ + 1'b1;
    else if (w_dec) w_occ_nxt = r_occ - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_pend_in   <= 1'b0;
      r_pend_out  <= 1'b0;
      r_gate_open <= 1'b0;
      r_gate_dir  <= DIR_IN;
      r_occ       <= '0;
      r_free      <= CAP_V;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_reject    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_reject  <= 1'b0;
      r_timeout <= 1'b0;
      r_occ     <= w_occ_nxt;
      r_free    <= CAP_V - w_occ_nxt;
      r_full    <= (w_occ_nxt == CAP_V);
      r_empty   <= (w_occ_nxt == '0);
      unique case (r_state)
        IDLE: begin
          if (w_src_out && !r_empty) begin
            r_state     <= OPEN_OUT;
            r_gate_open <= 1'b1;
            r_gate_dir  <= DIR_OUT;
            r_timer     <= '0;
            r_pend_out  <= 1'b0;
            if (w_e_ereq) r_pend_in <= 1'b1;
          end else begin
            // exit source while empty is simply dropped
            r_pend_out <= 1'b0;
            if (w_src_in && !r_full) begin
              r_state     <= OPEN_IN;
              r_gate_open <= 1'b1;
              r_gate_dir  <= DIR_IN;
              r_timer     <= '0;
              r_pend_in   <= 1'b0;
            end else if (w_src_in) begin
              r_reject  <= 1'b1;
              r_pend_in <= 1'b0;
            end
          end
        end
        OPEN_IN, OPEN_OUT: begin
          if (w_e_ereq) r_pend_in  <= 1'b1;
          if (w_e_xreq) r_pend_out <= 1'b1;
          if (w_pass) begin
            r_state     <= CLOSE;
            r_gate_open <= 1'b0;
          end else if (r_timer == TMO_V) begin
            r_state     <= CLOSE;
            r_gate_open <= 1'b0;
            r_timeout   <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        CLOSE: begin
          if (w_e_ereq) r_pend_in  <= 1'b1;
          if (w_e_xreq) r_pend_out <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_gate_open <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gate_open   = r_gate_open;
  assign bus.gate_dir    = r_gate_dir;
  assign bus.occupancy   = r_occ;
  assign bus.free_spaces = r_free;
  assign bus.full        = r_full;
  assign bus.empty       = r_empty;
  assign bus.reject      = r_reject;
  assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller.
// Inputs change 1ns after posedge; outputs sampled at the same point.
module tb_parking_gate_controller;
  import parking_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  parking_gate_if #(.CNT_W(4)) bus ();

  parking_gate_controller #(
    .CAPACITY    (8),
    .CNT_W       (4),
    .GATE_TIMEOUT(50),
    .TMR_W       (6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic er, input logic xr,
                       input logic ep, input logic xp);
    bus.entry_req  = er;
    bus.exit_req   = xr;
    bus.entry_pass = ep;
    bus.exit_pass  = xp;
  endtask

  // 0 entry_req, 1 exit_req, 2 entry_pass, 3 exit_pass
  task automatic pulse(input int sel);
    drive(sel == 0, sel == 1, sel == 2, sel == 3);
    step;
    drive(0, 0, 0, 0);
  endtask

  task automatic do_in;
    pulse(0);
    pulse(2);
    step;
  endtask

  task automatic do_out;
    pulse(1);
    pulse(3);
    step;
  endtask

  task automatic chk_stat(input string tag, input int go,
                          input int occ);
    check({tag, "_gate"}, int'(bus.gate_open), go);
    check({tag, "_occ"}, int'(bus.occupancy), occ);
  endtask

  initial begin
    int n;
    drive(0, 0, 0, 0);
    repeat (2) step;
    check("rst_gate", int'(bus.gate_open), 0);
    check("rst_dir", int'(bus.gate_dir), 0);
    check("rst_occ", int'(bus.occupancy), 0);
    check("rst_free", int'(bus.free_spaces), 8);
    check("rst_full", int'(bus.full), 0);
    check("rst_empty", int'(bus.empty), 1);
    check("rst_reject", int'(bus.reject), 0);
    check("rst_timeout", int'(bus.timeout), 0);
    reset = 1'b1;
    repeat (3) step;

    // test 1: basic entry
    pulse(0);
    check("t1_open", int'(bus.gate_open), 1);
    check("t1_dir", int'(bus.gate_dir), 0);
    repeat (3) step;
    pulse(3);
    chk_stat("t1_wrongpass", 1, 0);
    repeat (4) step;
    pulse(2);
    chk_stat("t1_closed", 0, 1);
    check("t1_empty", int'(bus.empty), 0);
    check("t1_free", int'(bus.free_spaces), 7);
    step;
    check("t1_idle_gate", int'(bus.gate_open), 0);

    // test 2: fill and reject
    repeat (7) do_in;
    check("t2_full", int'(bus.full), 1);
    check("t2_free", int'(bus.free_spaces), 0);
    check("t2_occ", int'(bus.occupancy), 8);
    pulse(0);
    check("t2_reject", int'(bus.reject), 1);
    check("t2_gate", int'(bus.gate_open), 0);
    step;
    check("t2_reject_end", int'(bus.reject), 0);
    chk_stat("t2_after", 0, 8);

    // test 3: exit then timeout on entry
    pulse(1);
    check("t3_out_open", int'(bus.gate_open), 1);
    check("t3_out_dir", int'(bus.gate_dir), 1);
    pulse(3);
    chk_stat("t3_out_done", 0, 7);
    check("t3_full", int'(bus.full), 0);
    step;
    pulse(0);
    n = 0;
    while (bus.gate_open && n < 100) begin
      n++;
      step;
    end
    check("t3_open_cycles", n, 50);
    check("t3_timeout", int'(bus.timeout), 1);
    check("t3_occ", int'(bus.occupancy), 7);
    step;
    check("t3_timeout_end", int'(bus.timeout), 0);
    step;

    // test 4: simultaneous entry and exit at occupancy 3
    repeat (4) do_out;
    check("t4_occ3", int'(bus.occupancy), 3);
    drive(1, 1, 0, 0);
    step;
    drive(0, 0, 0, 0);
    check("t4_open", int'(bus.gate_open), 1);
    check("t4_dir_out", int'(bus.gate_dir), 1);
    pulse(3);
    chk_stat("t4_close", 0, 2);
    step;
    check("t4_idle", int'(bus.gate_open), 0);
    step;
    check("t4_pend_open", int'(bus.gate_open), 1);
    check("t4_pend_dir", int'(bus.gate_dir), 0);
    pulse(2);
    chk_stat("t4_done", 0, 3);
    step;

    // test 5: entry held high through reset release
    drive(1, 0, 0, 0);
    reset = 1'b0;
    #2;
    chk_stat("t5_inrst", 0, 0);
    step;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      check("t5_held_gate", int'(bus.gate_open), 0);
    end
    bus.exit_req = 1'b1;
    step;
    chk_stat("t5_exit_empty", 0, 0);
    bus.exit_req = 1'b0;
    step;
    chk_stat("t5_after", 0, 0);
    check("t5_empty", int'(bus.empty), 1);
    bus.entry_req = 1'b0;
    step;

    // test 6: reset in OPEN_OUT with pending entry
    do_in;
    check("t6_occ1", int'(bus.occupancy), 1);
    pulse(1);
    check("t6_open_out", int'(bus.gate_open), 1);
    pulse(0);
    check("t6_still_open", int'(bus.gate_open), 1);
    #2;
    reset = 1'b0;
    #1;
    chk_stat("t6_rst", 0, 0);
    check("t6_empty", int'(bus.empty), 1);
    check("t6_free", int'(bus.free_spaces), 8);
    step;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      chk_stat("t6_noserv", 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Consumes the clean, active-high debounced sensor levels for the parking lot (entry request, exit request, entry pass, exit pass).
- Drives a single shared barrier gate and maintains the lot's occupancy count, full/empty flags and free-space count.
- Sits directly downstream of the per-sensor debouncers and upstream of the display/LED driver.

Parameters:
- CAPACITY, 8, number of parking spaces.
- CNT_W, 4, occupancy counter width; must hold CAPACITY.
- GATE_TIMEOUT, 50, cycles the gate stays open waiting for a pass before closing; must be at least 2.
- TMR_W, 6, timeout counter width; must hold GATE_TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- entry_req  in  1  debounced level; car waiting at the entry sensor
- exit_req  in  1  debounced level; car waiting at the exit sensor
- entry_pass  in  1  debounced level; car cleared the gate inward
- exit_pass  in  1  debounced level; car cleared the gate outward
- gate_open  out  1  barrier open command (registered)
- gate_dir  out  1  0 = inbound, 1 = outbound; valid while gate_open
- occupancy  out  CNT_W  cars currently parked
- free_spaces  out  CNT_W  CAPACITY − occupancy
- full  out  1  occupancy == CAPACITY
- empty  out  1  occupancy == 0
- reject  out  1  one-cycle pulse: entry request refused because the lot is full
- timeout  out  1  one-cycle pulse: gate closed with no pass detected

Behaviour:
- Reset values (asynchronous, while reset = 0):
  - gate_open = 0, gate_dir = 0, occupancy = 0, free_spaces = CAPACITY.
  - full = 0, empty = 1, reject = 0, timeout = 0.
  - State = IDLE, timer = 0, pending flags = 0.
- Edge detection:
  - Each input is rising-edge detected against a registered previous value. Previous-value registers reset to 1.
  - An input held high through reset release produces no edge.
  - Only edges act; levels are ignored.
- Pending flags: pend_in and pend_out, one deep each.
  - An edge arriving while the gate is busy sets the matching flag.
  - Repeated edges while the flag is set are absorbed.
- States: IDLE, OPEN_IN, OPEN_OUT, CLOSE.
- IDLE:
  - Service sources are the edge on the current cycle or the matching pending flag.
  - Exit is served first. If there is an exit source and occupancy > 0: go to OPEN_OUT and clear pend_out.
  - Otherwise, if there is an entry source and full = 0: go to OPEN_IN and clear pend_in.
  - An entry source while full: pulse reject in the same registered cycle, clear pend_in, stay in IDLE.
  - An exit source while empty: ignore it and clear pend_out.
  - If both sources are present: serve exit. Entry becomes or stays pending.
- OPEN_IN / OPEN_OUT:
  - gate_open = 1 and gate_dir is set on the cycle after the qualifying edge (latency 1).
  - The timer clears on entry to the state and increments each cycle.
  - Matching pass edge: move to CLOSE. Occupancy changes by +1 (OPEN_IN) or −1 (OPEN_OUT), visible on the same edge gate_open falls.
  - Pass edge for the opposite direction: ignored.
  - Timer reaches GATE_TIMEOUT − 1 with no pass: move to CLOSE, pulse timeout, leave occupancy unchanged.
  - Pass edge and timeout in the same cycle: the pass wins, with no timeout pulse.
- CLOSE: gate_open = 0 for exactly one cycle (barrier settle), then IDLE.
- Occupancy guards:
  - Increment is suppressed at CAPACITY; decrement is suppressed at 0. The counter never wraps.
  - full, empty and free_spaces are registered and update in the same cycle as occupancy.
- Reset mid-operation closes the gate immediately and discards pending and occupancy state.
- reject and timeout are never asserted for more than one consecutive cycle per event.

Decomposition:
- Shared package parking_pkg:
  - State enum gate_state_t {IDLE, OPEN_IN, OPEN_OUT, CLOSE}.
  - Direction constants DIR_IN = 0, DIR_OUT = 1.
  - Default CAPACITY and GATE_TIMEOUT constants.
- One sub-module, edge_detect:
  - Single-bit rising-edge detector with asynchronous active-low reset.
  - Previous-value register resets to 1.
  - Instantiated four times.
- FSM, timer, pending flags and counter live in the top level.

Test Plan:
1. Entry edge at cycle 10, entry_pass edge at cycle 20.
   - Required: gate_open = 1, gate_dir = 0 from cycle 11.
   - Required: gate_open = 0 and occupancy = 1 at cycle 21.
   - Required: CLOSE at 21, IDLE at 22; empty falls to 0.
2. Fill to CAPACITY = 8, then another entry edge.
   - Required: full = 1, free_spaces = 0.
   - Required: reject pulses for 1 cycle; gate_open stays 0; occupancy stays 8.
3. Entry edge with no pass.
   - Required: gate closes after 50 open cycles.
   - Required: timeout pulses for 1 cycle; occupancy unchanged.
4. Occupancy 3; entry and exit edges in the same cycle.
   - Required: OPEN_OUT first; after exit_pass, occupancy = 2.
   - Required: one CLOSE cycle, then OPEN_IN from the pending entry; after entry_pass, occupancy = 3.
5. entry_req held high across reset release.
   - Required: no gate opening.
   - Required: exit edge while empty is ignored; gate_open = 0 and occupancy = 0 throughout.
6. Assert reset while in OPEN_OUT with pend_in set.
   - Required: gate_open = 0 immediately, occupancy = 0, empty = 1.
   - Required: no service after release.
